// File: rtl/npc_unit.sv
// Next-PC unit for a MIPS-style single-cycle core.
// Holds the architectural PC and resolves jumps, conditional branches and
// register-indirect transfers. Optional features: a one-instruction delay
// slot, a trap on misaligned JR/JALR targets with EPC capture, a stall hold,
// and a saturating counter of taken transfers.
module npc_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_4180,
    parameter bit          DELAY_SLOT  = 1'b0,
    parameter bit          ALIGN_CHECK = 1'b1,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [3:0]       npc_op,
    input  logic [25:0]      target,
    input  logic [31:0]      imm_ext,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    output logic [31:0]      pc,
    output logic [31:0]      link_addr,
    output logic             taken,
    output logic             trap,
    output logic [31:0]      epc,
    output logic [CNT_W-1:0] taken_cnt
);

    // Control-transfer opcodes; codes 1010..1110 behave like ADD4.
    localparam logic [3:0] OP_J    = 4'b0000;
    localparam logic [3:0] OP_JAL  = 4'b0001;
    localparam logic [3:0] OP_BEQ  = 4'b0010;
    localparam logic [3:0] OP_BNE  = 4'b0011;
    localparam logic [3:0] OP_BGEZ = 4'b0100;
    localparam logic [3:0] OP_BGTZ = 4'b0101;
    localparam logic [3:0] OP_BLEZ = 4'b0110;
    localparam logic [3:0] OP_BLTZ = 4'b0111;
    localparam logic [3:0] OP_JR   = 4'b1000;
    localparam logic [3:0] OP_JALR = 4'b1001;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_SLOT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       epc_q, epc_d;
    logic [31:0]       pend_q, pend_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              trap_q, trap_d;

    logic [31:0]       pc4_s;
    logic [31:0]       br_tgt_s;
    logic [31:0]       j_tgt_s;
    logic [31:0]       dest_s;
    logic              cond_s;
    logic              is_jr_s;
    logic              run_s;
    logic              misalign_s;
    logic              rs_zero_s;

    assign pc4_s     = pc_q + 32'd4;
    assign br_tgt_s  = pc4_s + (imm_ext << 2);
    assign j_tgt_s   = {pc4_s[31:28], target, 2'b00};
    assign rs_zero_s = (rs_data == 32'd0);
    assign run_s     = (state_q == ST_RUN);

    // Decode the op into a branch condition and its destination address.
    always_comb begin
        cond_s  = 1'b0;
        dest_s  = pc4_s;
        is_jr_s = 1'b0;
        case (npc_op)
            OP_J, OP_JAL: begin
                cond_s = 1'b1;
                dest_s = j_tgt_s;
            end
            OP_BEQ: begin
                cond_s = (rs_data == rt_data);
                dest_s = br_tgt_s;
            end
            OP_BNE: begin
                cond_s = (rs_data != rt_data);
                dest_s = br_tgt_s;
            end
            OP_BGEZ: begin
                cond_s = ~rs_data[31];
                dest_s = br_tgt_s;
            end
            OP_BGTZ: begin
                cond_s = ~rs_data[31] & ~rs_zero_s;
                dest_s = br_tgt_s;
            end
            OP_BLEZ: begin
                cond_s = rs_data[31] | rs_zero_s;
                dest_s = br_tgt_s;
            end
            OP_BLTZ: begin
                cond_s = rs_data[31];
                dest_s = br_tgt_s;
            end
            OP_JR, OP_JALR: begin
                cond_s  = 1'b1;
                dest_s  = rs_data;
                is_jr_s = 1'b1;
            end
            default: begin
                cond_s  = 1'b0;
                dest_s  = pc4_s;
                is_jr_s = 1'b0;
            end
        endcase
    end

    // An op in the delay slot is ignored, so both taken and the trap check need RUN.
    assign taken      = cond_s & run_s;
    assign misalign_s = ALIGN_CHECK & run_s & is_jr_s & (rs_data[1:0] != 2'b00);
    assign link_addr  = DELAY_SLOT ? (pc_q + 32'd8) : pc4_s;

    // Next-state selection: stall holds everything, the slot drains the pending
    // target, a misaligned target overrides the redirect, else follow the op.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        trap_d  = 1'b0;
        if (stall) begin
            trap_d = 1'b0;
        end else if (state_q == ST_SLOT) begin
            pc_d    = pend_q;
            state_d = ST_RUN;
        end else if (misalign_s) begin
            pc_d   = TRAP_VECTOR;
            epc_d  = pc_q;
            trap_d = 1'b1;
        end else if (taken) begin
            if (&cnt_q) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (DELAY_SLOT) begin
                pend_d  = dest_s;
                pc_d    = pc4_s;
                state_d = ST_SLOT;
            end else begin
                pc_d    = dest_s;
                state_d = ST_RUN;
            end
        end else begin
            pc_d = pc4_s;
        end
    end

    // Architectural state, FSM and registered trap pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            epc_q   <= 32'd0;
            pend_q  <= 32'd0;
            cnt_q   <= {CNT_W{1'b0}};
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            trap_q  <= trap_d;
        end
    end

    assign pc        = pc_q;
    assign epc       = epc_q;
    assign taken_cnt = cnt_q;
    assign trap      = trap_q;

endmodule

// File: tb/tb_npc_unit.sv
// Bench for npc_unit: four instances in different configurations share one
// stimulus stream; an instruction-level model predicts every output each cycle,
// and directed literal checks pin the model's expectations.
//   inst 0: DELAY_SLOT=0 ALIGN_CHECK=1 CNT_W=16
//   inst 1: DELAY_SLOT=1 ALIGN_CHECK=1 CNT_W=16
//   inst 2: DELAY_SLOT=0 ALIGN_CHECK=0 CNT_W=16
//   inst 3: DELAY_SLOT=0 ALIGN_CHECK=1 CNT_W=2
module tb_npc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [3:0]  npc_op = 4'hF;
    logic [25:0] target = 26'd0;
    logic [31:0] imm_ext = 32'd0;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] rt_data = 32'd0;

    logic [31:0] d_pc[4];
    logic [31:0] d_link[4];
    logic        d_taken[4];
    logic        d_trap[4];
    logic [31:0] d_epc[4];
    logic [15:0] d_cnt[4];
    logic [1:0]  cnt3;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    npc_unit #(.DELAY_SLOT(1'b0), .ALIGN_CHECK(1'b1), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .stall(stall), .npc_op(npc_op), .target(target),
        .imm_ext(imm_ext), .rs_data(rs_data), .rt_data(rt_data),
        .pc(d_pc[0]), .link_addr(d_link[0]), .taken(d_taken[0]), .trap(d_trap[0]),
        .epc(d_epc[0]), .taken_cnt(d_cnt[0]));
    npc_unit #(.DELAY_SLOT(1'b1), .ALIGN_CHECK(1'b1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .stall(stall), .npc_op(npc_op), .target(target),
        .imm_ext(imm_ext), .rs_data(rs_data), .rt_data(rt_data),
        .pc(d_pc[1]), .link_addr(d_link[1]), .taken(d_taken[1]), .trap(d_trap[1]),
        .epc(d_epc[1]), .taken_cnt(d_cnt[1]));
    npc_unit #(.DELAY_SLOT(1'b0), .ALIGN_CHECK(1'b0), .CNT_W(16)) u2 (
        .clk(clk), .rst(rst), .stall(stall), .npc_op(npc_op), .target(target),
        .imm_ext(imm_ext), .rs_data(rs_data), .rt_data(rt_data),
        .pc(d_pc[2]), .link_addr(d_link[2]), .taken(d_taken[2]), .trap(d_trap[2]),
        .epc(d_epc[2]), .taken_cnt(d_cnt[2]));
    npc_unit #(.DELAY_SLOT(1'b0), .ALIGN_CHECK(1'b1), .CNT_W(2)) u3 (
        .clk(clk), .rst(rst), .stall(stall), .npc_op(npc_op), .target(target),
        .imm_ext(imm_ext), .rs_data(rs_data), .rt_data(rt_data),
        .pc(d_pc[3]), .link_addr(d_link[3]), .taken(d_taken[3]), .trap(d_trap[3]),
        .epc(d_epc[3]), .taken_cnt(cnt3));
    assign d_cnt[3] = {14'd0, cnt3};

    // ---------------- reference model ----------------
    function automatic bit cfg_ds(int k);
        return (k == 1);
    endfunction
    function automatic bit cfg_ac(int k);
        return (k != 2);
    endfunction
    function automatic int unsigned cfg_max(int k);
        return (k == 3) ? 32'd3 : 32'd65535;
    endfunction

    // Branch condition straight from the instruction semantics.
    function automatic bit m_cond(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            4'd0, 4'd1, 4'd8, 4'd9: return 1'b1;
            4'd2: return (a == b);
            4'd3: return (a != b);
            4'd4: return ($signed(a) >= 32'sd0);
            4'd5: return ($signed(a) >  32'sd0);
            4'd6: return ($signed(a) <= 32'sd0);
            4'd7: return ($signed(a) <  32'sd0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_dest(logic [3:0] op, logic [31:0] p,
                                           logic [25:0] t, logic [31:0] imm,
                                           logic [31:0] rs);
        logic [31:0] nxt;
        nxt = p + 32'd4;
        case (op)
            4'd0, 4'd1: return {nxt[31:28], t, 2'b00};
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: return nxt + imm * 32'd4;
            4'd8, 4'd9: return rs;
            default: return nxt;
        endcase
    endfunction

    function automatic bit m_misaligned(int k, logic [3:0] op, logic [31:0] rs);
        return cfg_ac(k) && (op == 4'd8 || op == 4'd9) && (rs[1:0] != 2'b00);
    endfunction

    logic [31:0] m_pc[4], m_epc[4], m_pend[4];
    int unsigned m_cnt[4];
    bit          m_trap[4], m_slot[4];

    // Model advance: one instruction per non-stalled clock.
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                m_pc[k] <= 32'h0000_3000; m_epc[k] <= 32'd0; m_pend[k] <= 32'd0;
                m_cnt[k] <= 0; m_trap[k] <= 1'b0; m_slot[k] <= 1'b0;
            end else if (stall) begin
                m_trap[k] <= 1'b0;
            end else if (m_slot[k]) begin
                m_pc[k] <= m_pend[k]; m_slot[k] <= 1'b0; m_trap[k] <= 1'b0;
            end else if (m_misaligned(k, npc_op, rs_data)) begin
                m_pc[k] <= 32'h0000_4180; m_epc[k] <= m_pc[k]; m_trap[k] <= 1'b1;
            end else begin
                m_trap[k] <= 1'b0;
                if (m_cond(npc_op, rs_data, rt_data)) begin
                    if (m_cnt[k] < cfg_max(k)) m_cnt[k] <= m_cnt[k] + 1;
                    if (cfg_ds(k)) begin
                        m_pend[k] <= m_dest(npc_op, m_pc[k], target, imm_ext, rs_data);
                        m_pc[k]   <= m_pc[k] + 32'd4;
                        m_slot[k] <= 1'b1;
                    end else begin
                        m_pc[k] <= m_dest(npc_op, m_pc[k], target, imm_ext, rs_data);
                    end
                end else begin
                    m_pc[k] <= m_pc[k] + 32'd4;
                end
            end
        end
    end

    task automatic check(string name, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[inst%0d] got %h expected %h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            for (int k = 0; k < 4; k++) begin
                check("pc", k, d_pc[k], m_pc[k]);
                check("epc", k, d_epc[k], m_epc[k]);
                check("cnt", k, {16'd0, d_cnt[k]}, m_cnt[k]);
                check("trap", k, {31'd0, d_trap[k]}, {31'd0, m_trap[k]});
                check("taken", k, {31'd0, d_taken[k]},
                      {31'd0, m_cond(npc_op, rs_data, rt_data) && !m_slot[k]});
                check("link", k, d_link[k], m_pc[k] + (cfg_ds(k) ? 32'd8 : 32'd4));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        npc_op = 4'hF; stall = 1'b0; rs_data = 32'd0; rt_data = 32'd0;
        imm_ext = 32'd0; target = 26'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct { logic [31:0] rs; logic [3:0] op; bit exp; } sv_t;
    sv_t svec[8];

    initial begin
        svec[0] = '{32'h8000_0000, 4'd7, 1'b1};
        svec[1] = '{32'h8000_0000, 4'd4, 1'b0};
        svec[2] = '{32'h8000_0000, 4'd6, 1'b1};
        svec[3] = '{32'h8000_0000, 4'd5, 1'b0};
        svec[4] = '{32'h0000_0000, 4'd4, 1'b1};
        svec[5] = '{32'h0000_0000, 4'd6, 1'b1};
        svec[6] = '{32'h0000_0000, 4'd5, 1'b0};
        svec[7] = '{32'h0000_0000, 4'd7, 1'b0};

        // 1: reset release and sequential fetch
        do_reset();
        chk_en = 1'b1;
        check("lit_reset_pc", 0, d_pc[0], 32'h0000_3000);
        check("lit_reset_cnt", 0, {16'd0, d_cnt[0]}, 32'd0);
        tick(); check("lit_pc", 0, d_pc[0], 32'h0000_3004);
        tick(); check("lit_pc", 0, d_pc[0], 32'h0000_3008);
        tick(); check("lit_pc", 0, d_pc[0], 32'h0000_300C);
        check("lit_cnt", 0, {16'd0, d_cnt[0]}, 32'd0);

        // 2: BEQ backwards, taken and not taken
        tick(); check("lit_pc", 0, d_pc[0], 32'h0000_3010);
        npc_op = 4'd2; rs_data = 32'd5; rt_data = 32'd5; imm_ext = 32'hFFFF_FFFE;
        #1 check("lit_beq_taken", 0, {31'd0, d_taken[0]}, 32'd1);
        tick(); check("lit_beq_pc", 0, d_pc[0], 32'h0000_300C);
        check("lit_beq_cnt", 0, {16'd0, d_cnt[0]}, 32'd1);
        npc_op = 4'hF;
        tick();
        npc_op = 4'd2; rt_data = 32'd6;
        #1 check("lit_beq_nt", 0, {31'd0, d_taken[0]}, 32'd0);
        tick(); check("lit_beq_nt_pc", 0, d_pc[0], 32'h0000_3014);

        // 3: delay slot with JAL, branch in the slot ignored
        do_reset();
        npc_op = 4'd1; target = 26'h0000C40;
        #1 check("lit_link_ds", 1, d_link[1], 32'h0000_3008);
        check("lit_link_nods", 0, d_link[0], 32'h0000_3004);
        tick(); check("lit_slot_pc", 1, d_pc[1], 32'h0000_3004);
        check("lit_jal_pc", 0, d_pc[0], 32'h0000_3100);
        npc_op = 4'd3; rs_data = 32'd1; rt_data = 32'd2; imm_ext = 32'h0000_0010;
        #1 check("lit_slot_taken", 1, {31'd0, d_taken[1]}, 32'd0);
        tick(); check("lit_slot_dest", 1, d_pc[1], 32'h0000_3100);
        check("lit_slot_cnt", 1, {16'd0, d_cnt[1]}, 32'd1);
        npc_op = 4'hF;
        tick(); check("lit_after_slot", 1, d_pc[1], 32'h0000_3104);

        // 4: signed branch conditions (stalled so the PC stays put)
        stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            npc_op = svec[i].op; rs_data = svec[i].rs; rt_data = 32'd0;
            #1 check("lit_signed", 0, {31'd0, d_taken[0]}, {31'd0, svec[i].exp});
            tick();
        end
        stall = 1'b0;

        // 5: misaligned JR trap versus unchecked load
        do_reset();
        repeat (8) tick();
        check("lit_pre_jr", 0, d_pc[0], 32'h0000_3020);
        npc_op = 4'd8; rs_data = 32'h0000_3402;
        tick();
        check("lit_trap_pc", 0, d_pc[0], 32'h0000_4180);
        check("lit_trap", 0, {31'd0, d_trap[0]}, 32'd1);
        check("lit_epc", 0, d_epc[0], 32'h0000_3020);
        check("lit_trap_cnt", 0, {16'd0, d_cnt[0]}, 32'd0);
        check("lit_noalign_pc", 2, d_pc[2], 32'h0000_3402);
        check("lit_noalign_trap", 2, {31'd0, d_trap[2]}, 32'd0);
        npc_op = 4'hF; rs_data = 32'd0;
        tick();
        check("lit_trap_pulse", 0, {31'd0, d_trap[0]}, 32'd0);
        check("lit_trap_ds_run", 1, d_pc[1], 32'h0000_4184);

        // 6a: stall held in the slot, then release
        do_reset();
        npc_op = 4'd0; target = 26'h0000C40;
        tick(); npc_op = 4'hF; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check("lit_stall_pc", 1, d_pc[1], 32'h0000_3004);
        end
        stall = 1'b0;
        tick(); check("lit_stall_rel", 1, d_pc[1], 32'h0000_3100);

        // 6b: async reset in the middle of a slot
        npc_op = 4'd0;
        tick(); check("lit_slot2", 1, d_pc[1], 32'h0000_3104);
        npc_op = 4'hF;
        #2 rst = 1'b1;
        #1 check("lit_async_rst", 1, d_pc[1], 32'h0000_3000);
        @(posedge clk); #1 rst = 1'b0;
        tick(); check("lit_rst_run", 1, d_pc[1], 32'h0000_3004);

        // 6c: counter saturation
        do_reset();
        npc_op = 4'd0; target = 26'h0000C40;
        repeat (5) tick();
        check("lit_sat", 3, {16'd0, d_cnt[3]}, 32'd3);
        check("lit_cnt5", 0, {16'd0, d_cnt[0]}, 32'd5);
        npc_op = 4'hF;
        tick();

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/npc_unit.md
Name: npc_unit

Overview:
- Parametrised next-PC unit for the MIPS-style single-cycle core.
- Holds the architectural PC register and resolves the full control-transfer set: J, JAL, BEQ, BNE, BGEZ, BGTZ, BLEZ, BLTZ, JR, JALR.
- Branch comparison is done internally on rs/rt operands.
- Adds an optional branch delay slot, misaligned-target trap with EPC capture, stall hold, and a taken-transfer counter.
- Sits between the decoder/register file and instruction memory.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_4180, PC loaded on a misaligned-target trap.
- DELAY_SLOT, 0, 1 = MIPS delay-slot semantics; 0 = immediate redirect.
- ALIGN_CHECK, 1, 1 = trap on JR/JALR targets with target[1:0] != 0; 0 = no check.
- CNT_W, 16, width of the taken-transfer counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- stall  in  1  hold PC, FSM, EPC and counter this cycle.
- npc_op  in  4  op code: 0000 J, 0001 JAL, 0010 BEQ, 0011 BNE, 0100 BGEZ, 0101 BGTZ, 0110 BLEZ, 0111 BLTZ, 1000 JR, 1001 JALR, 1111 ADD4.
- target  in  26  jump index field.
- imm_ext  in  32  sign-extended branch offset.
- rs_data  in  32  rs operand; also the JR/JALR target.
- rt_data  in  32  rt operand.
- pc  out  32  current PC, registered.
- link_addr  out  32  return address for JAL/JALR, combinational.
- taken  out  1  current op redirects control flow, combinational.
- trap  out  1  one-cycle pulse on misaligned-target trap.
- epc  out  32  PC of the faulting instruction, registered.
- taken_cnt  out  CNT_W  saturating count of taken transfers.

Behaviour:
- Reset (async, any time, including mid-slot):
  - pc=RESET_PC, epc=0, taken_cnt=0, trap=0, FSM=RUN, pending target=0.
- Arithmetic:
  - pc4 = pc+4, modulo 2^32.
  - Branch target = pc4 + (imm_ext<<2), modulo 2^32, overflow ignored.
  - Jump target = {pc4[31:28], target, 2'b00}.
  - JR/JALR target = rs_data.
- Conditions:
  - BEQ: rs==rt. BNE: rs!=rt.
  - BGEZ, BGTZ, BLEZ, BLTZ: signed compare of rs against 0.
  - J, JAL, JR, JALR: always taken.
  - ADD4 and unlisted codes (1010-1110): never taken; treated as ADD4.
- taken = condition true AND FSM==RUN. It is 0 during SLOT.
- link_addr = pc+8 when DELAY_SLOT=1, else pc+4. Driven for every op; the consumer qualifies it.
- FSM states: RUN and SLOT. SLOT is used only when DELAY_SLOT=1.
  - RUN, not taken: pc <= pc4.
  - RUN, taken, DELAY_SLOT=0: pc <= computed target.
  - RUN, taken, DELAY_SLOT=1: pending <= computed target, pc <= pc4, go to SLOT.
  - SLOT: pc <= pending, go to RUN. npc_op is ignored (no taken, no count, no trap check); a branch in a delay slot has no effect.
- Trap (ALIGN_CHECK=1, RUN, op JR/JALR, rs_data[1:0]!=0):
  - Overrides the redirect: pc <= TRAP_VECTOR, epc <= pc, trap=1 for that cycle.
  - FSM stays in RUN, even with DELAY_SLOT=1.
  - taken_cnt is not incremented.
  - trap is a registered pulse, asserted the cycle after detection alongside the new pc.
- taken_cnt increments by 1 on each non-stalled RUN cycle with taken=1 and no trap. Saturates at all-ones.
- stall=1:
  - All registers hold; trap output is 0.
  - Combinational taken/link_addr remain valid.
  - A pending SLOT redirect is retained until the first non-stalled cycle.
- ALIGN_CHECK=0: misaligned JR targets load unchanged.

Test Plan:
1. Reset release, 3 cycles ADD4 -> pc 0x3000, 0x3004, 0x3008, 0x300C; taken_cnt=0.
2. DELAY_SLOT=0, pc=0x3010, BEQ with rs=rt=5, imm_ext=0xFFFF_FFFE -> next pc=0x300C, taken=1, taken_cnt=1. Same with rt=6 -> pc=0x3014, taken=0.
3. DELAY_SLOT=1, pc=0x3000, J target=0x0000C40 -> pc 0x3004, then 0x0000_3100. A BNE taken in the slot is ignored; taken_cnt=1; link_addr at JAL = 0x3008.
4. Signed branches, rs=0x8000_0000: BLTZ taken, BGEZ not, BLEZ taken, BGTZ not. rs=0: BGEZ and BLEZ taken, BGTZ and BLTZ not.
5. pc=0x3020, JR rs=0x0000_3402 -> next pc=0x4180, trap pulse one cycle, epc=0x3020, taken_cnt unchanged. Same with ALIGN_CHECK=0 -> pc=0x3402, no trap.
6. Stall held 3 cycles while in SLOT, then released -> pc frozen throughout, then loads pending. rst asserted mid-SLOT -> pc=0x3000 immediately, FSM=RUN. CNT_W=2 with 5 taken jumps -> taken_cnt saturates at 3.
